cluster_load_sequencer: RTL

// Top-level load/compute scheduler for one PE cluster. Sequences the weight router, then the

---
 rtl/cluster_load_sequencer.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/cluster_load_sequencer.sv
// Per-pass scheduler for one PE cluster: weight load, iact load, PE run, psum write-back.
// Every control output is a registered single-cycle pulse, so the routers never see a held load.
module cluster_load_sequencer #(
    parameter int ACT_SIZE      = 5,
    parameter int KERNEL_SIZE   = 3,
    parameter int IACT_LOAD_CYC = ACT_SIZE**2 + 2,
    parameter int WGHT_LOAD_CYC = KERNEL_SIZE**2 + 2,
    parameter int PASS_BITWIDTH = 8,
    parameter int TIMEOUT_CYC   = 4096
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic [PASS_BITWIDTH-1:0] num_passes,
    input  logic                     reuse_weights,
    input  logic                     pe_done,
    input  logic                     wb_done,
    output logic                     load_spad_wght,
    output logic                     load_spad_iact,
    output logic                     pe_start,
    output logic                     psum_wb_start,
    output logic [PASS_BITWIDTH-1:0] pass_idx,
    output logic                     busy,
    output logic                     job_done,
    output logic                     error
);
    localparam int LOAD_MAX = (IACT_LOAD_CYC > WGHT_LOAD_CYC) ? IACT_LOAD_CYC : WGHT_LOAD_CYC;
    localparam int CNT_W    = $clog2(LOAD_MAX + 1);
    localparam int TO_W     = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [3:0] {
        S_IDLE, S_LOAD_W, S_WAIT_W, S_LOAD_I, S_WAIT_I,
        S_RUN, S_WAIT_PE, S_WB, S_WAIT_WB, S_DONE
    } state_t;

    state_t                   state_q, state_d;
    logic [CNT_W-1:0]         load_cnt_q, load_cnt_d;
    logic [TO_W-1:0]          to_cnt_q, to_cnt_d;
    logic [PASS_BITWIDTH-1:0] pass_idx_q, pass_idx_d;
    logic [PASS_BITWIDTH-1:0] num_passes_q, num_passes_d;
    logic                     reuse_q, reuse_d;
    logic                     wght_q, wght_d;
    logic                     iact_q, iact_d;
    logic                     pe_start_q, pe_start_d;
    logic                     wb_start_q, wb_start_d;
    logic                     job_done_q, job_done_d;
    logic                     busy_q, busy_d;
    logic                     error_q, error_d;

    always_comb begin
        state_d      = state_q;
        load_cnt_d   = load_cnt_q;
        to_cnt_d     = to_cnt_q;
        pass_idx_d   = pass_idx_q;
        num_passes_d = num_passes_q;
        reuse_d      = reuse_q;
        error_d      = error_q;
        wght_d       = 1'b0;
        iact_d       = 1'b0;
        pe_start_d   = 1'b0;
        wb_start_d   = 1'b0;
        job_done_d   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    num_passes_d = (num_passes == '0) ? PASS_BITWIDTH'(1) : num_passes;
                    reuse_d      = reuse_weights;
                    pass_idx_d   = '0;
                    error_d      = 1'b0;
                    state_d      = S_LOAD_W;
                end
            end
            S_LOAD_W: begin
                if (pass_idx_q == '0 || !reuse_q) begin
                    wght_d     = 1'b1;
                    // The window counts to 0 inclusive and LOAD_I adds one more cycle.
                    load_cnt_d = CNT_W'(WGHT_LOAD_CYC - 2);
                    state_d    = S_WAIT_W;
                end else begin
                    state_d = S_LOAD_I;
                end
            end
            S_WAIT_W: begin
                if (load_cnt_q == '0) state_d = S_LOAD_I;
                else                  load_cnt_d = load_cnt_q - CNT_W'(1);
            end
            S_LOAD_I: begin
                iact_d     = 1'b1;
                load_cnt_d = CNT_W'(IACT_LOAD_CYC - 2);
                state_d    = S_WAIT_I;
            end
            S_WAIT_I: begin
                if (load_cnt_q == '0) state_d = S_RUN;
                else                  load_cnt_d = load_cnt_q - CNT_W'(1);
            end
            S_RUN: begin
                pe_start_d = 1'b1;
                to_cnt_d   = '0;
                state_d    = S_WAIT_PE;
            end
            S_WAIT_PE: begin
                if (pe_done) begin
                    state_d = S_WB;
                end else if (to_cnt_q == TO_W'(TIMEOUT_CYC - 1)) begin
                    error_d = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    to_cnt_d = to_cnt_q + TO_W'(1);
                end
            end
            S_WB: begin
                wb_start_d = 1'b1;
                to_cnt_d   = '0;
                state_d    = S_WAIT_WB;
            end
            S_WAIT_WB: begin
                if (wb_done) begin
                    if (pass_idx_q == num_passes_q - PASS_BITWIDTH'(1)) begin
                        state_d = S_DONE;
                    end else begin
                        pass_idx_d = pass_idx_q + PASS_BITWIDTH'(1);
                        state_d    = S_LOAD_W;
                    end
                end else if (to_cnt_q == TO_W'(TIMEOUT_CYC - 1)) begin
                    error_d = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    to_cnt_d = to_cnt_q + TO_W'(1);
                end
            end
            S_DONE: begin
                job_done_d = 1'b1;
                state_d    = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            load_cnt_q   <= '0;
            to_cnt_q     <= '0;
            pass_idx_q   <= '0;
            num_passes_q <= '0;
            reuse_q      <= 1'b0;
            wght_q       <= 1'b0;
            iact_q       <= 1'b0;
            pe_start_q   <= 1'b0;
            wb_start_q   <= 1'b0;
            job_done_q   <= 1'b0;
            busy_q       <= 1'b0;
            error_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            load_cnt_q   <= load_cnt_d;
            to_cnt_q     <= to_cnt_d;
            pass_idx_q   <= pass_idx_d;
            num_passes_q <= num_passes_d;
            reuse_q      <= reuse_d;
            wght_q       <= wght_d;
            iact_q       <= iact_d;
            pe_start_q   <= pe_start_d;
            wb_start_q   <= wb_start_d;
            job_done_q   <= job_done_d;
            busy_q       <= busy_d;
            error_q      <= error_d;
        end
    end

    assign load_spad_wght = wght_q;
    assign load_spad_iact = iact_q;
    assign pe_start       = pe_start_q;
    assign psum_wb_start  = wb_start_q;
    assign pass_idx       = pass_idx_q;
    assign busy           = busy_q;
    assign job_done       = job_done_q;
    assign error          = error_q;

endmodule
